// File: rtl/shift_taps_seq_ctrl.sv
// Sequencer for an unreset 8x64 tapped shift register: accepts bytes, drives
// one shift per accepted byte, qualifies the 4-tap window once full, and purges on flush.
module shift_taps_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 7,
  parameter int WCNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               flush,
  output logic               sr_shift,
  output logic [WIDTH-1:0]   sr_din,
  input  logic [WIDTH-1:0]   sr_tap0,
  input  logic [WIDTH-1:0]   sr_tap1,
  input  logic [WIDTH-1:0]   sr_tap2,
  input  logic [WIDTH-1:0]   sr_tap3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WIDTH-1:0] out_window,
  output logic [CNT_W-1:0]   fill_level,
  output logic               busy_flush,
  output logic [WCNT_W-1:0]  win_count
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_fill, w_fill_nxt;
  logic [CNT_W-1:0]    r_flush_cnt, w_flush_cnt_nxt;
  logic [WCNT_W-1:0]   r_win_count;
  logic                w_accept;

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_fill_nxt      = r_fill;
    w_flush_cnt_nxt = r_flush_cnt;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    busy_flush      = 1'b0;

    // A flush request blocks the byte offered in the same cycle.
    case (r_state)
      S_FILL:  in_ready = !flush;
      S_RUN: begin
        in_ready  = out_ready && !flush;
        out_valid = 1'b1;
      end
      S_FLUSH: busy_flush = 1'b1;
      default: ;
    endcase

    w_accept = in_valid && in_ready;
    sr_shift = w_accept || (r_state == S_FLUSH);
    sr_din   = w_accept ? in_data : '0;

    if (flush) begin
      w_state_nxt     = S_FLUSH;
      w_flush_cnt_nxt = '0;
      w_fill_nxt      = '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            w_fill_nxt = r_fill + CNT_W'(1);
            if (r_fill == LAST) w_state_nxt = S_RUN;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == LAST) begin
            w_state_nxt     = S_FILL;
            w_flush_cnt_nxt = '0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_fill      <= '0;
      r_flush_cnt <= '0;
      r_win_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill      <= w_fill_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (out_valid && out_ready && (r_win_count != '1))
        r_win_count <= r_win_count + WCNT_W'(1);
    end
  end

  assign out_window = {sr_tap3, sr_tap2, sr_tap1, sr_tap0};
  assign fill_level = r_fill;
  assign win_count  = r_win_count;

endmodule

// File: tb/tb_shift_taps_seq_ctrl.sv
// Directed bench for shift_taps_seq_ctrl, with a behavioural 8x64 shift register
// feeding the taps and a narrow-counter instance for saturation.
module tb_shift_taps_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, sr_shift, out_valid, out_ready, busy_flush;
  logic [7:0]  in_data, sr_din, tap0, tap1, tap2, tap3;
  logic [31:0] out_window;
  logic [6:0]  fill_level;
  logic [15:0] win_count;

  logic        b_in_valid, b_in_ready, b_flush, b_sr_shift, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_in_data, b_sr_din;
  logic [31:0] b_window;
  logic [6:0]  b_fill;
  logic [1:0]  b_win_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] sr_mem [64];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sr_shift) begin
      for (int i = 63; i > 0; i--) sr_mem[i] <= sr_mem[i-1];
      sr_mem[0] <= sr_din;
    end
  end

  assign tap0 = sr_mem[15];
  assign tap1 = sr_mem[31];
  assign tap2 = sr_mem[47];
  assign tap3 = sr_mem[63];

  shift_taps_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .sr_shift(sr_shift), .sr_din(sr_din),
    .sr_tap0(tap0), .sr_tap1(tap1), .sr_tap2(tap2), .sr_tap3(tap3),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .fill_level(fill_level), .busy_flush(busy_flush), .win_count(win_count)
  );

  shift_taps_seq_ctrl #(.WCNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush), .sr_shift(b_sr_shift), .sr_din(b_sr_din),
    .sr_tap0(8'h00), .sr_tap1(8'h00), .sr_tap2(8'h00), .sr_tap3(8'h00),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_window(b_window),
    .fill_level(b_fill), .busy_flush(b_busy), .win_count(b_win_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({fill_level, out_valid, in_ready, sr_shift, busy_flush, win_count} !==
        {7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL reset_state: fill=%0d ov=%b ir=%b sh=%b bf=%b wc=%0d, want 0 0 1 0 0 0",
               fill_level, out_valid, in_ready, sr_shift, busy_flush, win_count);
    end
  endtask

  task automatic test_fill_run();
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      #1;
      total++;
      if ({in_ready, sr_shift, sr_din, out_valid} !== {1'b1, 1'b1, in_data, 1'b0}) begin
        bad++;
        $display("FAIL fill_byte%0d: ir=%b sh=%b din=%h ov=%b, want 1 1 %h 0",
                 i, in_ready, sr_shift, sr_din, out_valid, in_data);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL run_valid: out_valid=%b want 1", out_valid);
    end
    total++;
    if (out_window !== 32'h01112131) begin
      bad++; $display("FAIL first_window: got %h want 01112131", out_window);
    end
    total++;
    if ({in_ready, fill_level} !== {1'b0, 7'd64}) begin
      bad++; $display("FAIL run_stall: ir=%b fill=%0d want 0 64", in_ready, fill_level);
    end
  endtask

  task automatic test_consume_shift();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h41;
    #1;
    total++;
    if ({in_ready, sr_shift, sr_din} !== {1'b1, 1'b1, 8'h41}) begin
      bad++; $display("FAIL run_accept: ir=%b sh=%b din=%h want 1 1 41", in_ready, sr_shift, sr_din);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if ({out_valid, out_window, win_count} !== {1'b1, 32'h02122232, 16'd1}) begin
      bad++; $display("FAIL window_update: ov=%b win=%h wc=%0d want 1 02122232 1",
                      out_valid, out_window, win_count);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if ({sr_shift, sr_din} !== {1'b0, 8'h00}) begin
      bad++; $display("FAIL consume_noshift: sh=%b din=%h want 0 00", sr_shift, sr_din);
    end
    tick();
    out_ready = 1'b0;
    #1;
    total++;
    if ({out_valid, out_window, win_count} !== {1'b1, 32'h02122232, 16'd2}) begin
      bad++; $display("FAIL represent: ov=%b win=%h wc=%0d want 1 02122232 2",
                      out_valid, out_window, win_count);
    end
  endtask

  task automatic test_partial_fill();
    do_reset();
    load(63, 8'h80);
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({out_valid, sr_shift} !== 2'b00) begin
        bad++; $display("FAIL idle%0d: ov=%b sh=%b want 0 0", i, out_valid, sr_shift);
      end
      tick();
    end
    total++;
    if (fill_level !== 7'd63) begin
      bad++; $display("FAIL fill63: got %0d want 63", fill_level);
    end
    load(1, 8'hC0);
    #1;
    total++;
    if ({out_valid, out_window} !== {1'b1, 32'h8090A0B0}) begin
      bad++; $display("FAIL last_byte: ov=%b win=%h want 1 8090a0b0", out_valid, out_window);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    #1;
    total++;
    if ({in_ready, sr_shift, sr_din} !== {1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL flush_drop: ir=%b sh=%b din=%h want 0 0 00", in_ready, sr_shift, sr_din);
    end
    tick();
    flush = 1'b0; in_data = 8'h55;
    for (int i = 0; i < 64; i++) begin
      #1;
      total++;
      if ({busy_flush, sr_shift, sr_din, out_valid, in_ready} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
        bad++; $display("FAIL flush_cycle%0d: bf=%b sh=%b din=%h ov=%b ir=%b want 1 1 00 0 0",
                        i, busy_flush, sr_shift, sr_din, out_valid, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if ({busy_flush, fill_level, in_ready, sr_shift} !== {1'b0, 7'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL flush_done: bf=%b fill=%0d ir=%b sh=%b want 0 0 1 0",
                      busy_flush, fill_level, in_ready, sr_shift);
    end
    total++;
    if (out_window !== 32'h0) begin
      bad++; $display("FAIL flush_taps: got %h want 00000000", out_window);
    end
  endtask

  task automatic test_flush_restart();
    int n;
    load(5, 8'h01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    forever begin
      #1;
      if (!busy_flush || n >= 200) break;
      flush = (n == 10);
      n++;
      tick();
      flush = 1'b0;
    end
    total++;
    if (n !== 75) begin
      bad++; $display("FAIL flush_restart_len: busy cycles=%0d want 75", n);
    end
    total++;
    if ({fill_level, in_ready} !== {7'd0, 1'b1}) begin
      bad++; $display("FAIL flush_restart_end: fill=%0d ir=%b want 0 1", fill_level, in_ready);
    end
  endtask

  task automatic test_async_reset();
    load(30, 8'h70);
    #1;
    total++;
    if (fill_level !== 7'd30) begin
      bad++; $display("FAIL fill30: got %0d want 30", fill_level);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({fill_level, out_valid} !== {7'd0, 1'b0}) begin
      bad++; $display("FAIL async_reset: fill=%0d ov=%b want 0 0", fill_level, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load(63, 8'h10);
    #1;
    total++;
    if ({out_valid, fill_level} !== {1'b0, 7'd63}) begin
      bad++; $display("FAIL refill63: ov=%b fill=%0d want 0 63", out_valid, fill_level);
    end
    load(1, 8'h4F);
    #1;
    total++;
    if ({out_valid, out_window} !== {1'b1, 32'h10203040}) begin
      bad++; $display("FAIL refill64: ov=%b win=%h want 1 10203040", out_valid, out_window);
    end
  endtask

  task automatic test_win_saturate();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'(i);
      tick();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    #1;
    total++;
    if ({b_out_valid, b_win_count} !== {1'b1, 2'd0}) begin
      bad++; $display("FAIL sat_start: ov=%b wc=%0d want 1 0", b_out_valid, b_win_count);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (b_win_count !== ((k < 3) ? 2'(k) : 2'd3)) begin
        bad++; $display("FAIL sat_count%0d: got %0d want %0d", k, b_win_count, (k < 3) ? k : 3);
      end
    end
    b_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_run();
    test_consume_shift();
    test_partial_fill();
    test_flush();
    test_flush_restart();
    test_async_reset();
    test_win_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
